instr_fetch: RTL

- Instruction fetch stage directly upstream of the execute unit (movsgpr/mov/add/sub/mul decode on IR[31:27]).
- Holds the PC and reads 32-bit instruction words from a synchronous instruction memory (1-cycle read latency).
- Presents each word as `ir` to execute over a valid/ready handshake.
- Supports PC redirect (jump), a HALT encoding, and start/resume control.

---
 rtl/instr_fetch.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage feeding the execute unit.
//
// Holds the PC and reads 32-bit words from a synchronous instruction
// memory with a 1-cycle read latency. Each word goes to execute as `ir`.
// A word whose IR[31:27] equals HALT_OP is never forwarded. Instead the
// stage parks in HALTED until the next start pulse.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst_n        in   synchronous active-low reset
//   start        in   one-cycle pulse, leaves IDLE / HALTED
//   jump_en      in   redirect request
//   jump_addr    in   redirect target [ADDR_W]
//   imem_en      out  memory read strobe (high in FETCH)
//   imem_addr    out  memory read address, always equal to pc
//   imem_rdata   in   read data, valid the cycle after imem_en
//   ir           out  instruction presented to execute
//   ir_valid     out  ir holds an unconsumed instruction
//   ir_ready     in   execute accepts ir
//   pc           out  current fetch PC
//   halted       out  HALT encountered, fetch parked
//   instr_count  out  instructions handed off (saturating)
//   stall_count  out  cycles with ir_valid=1 and ir_ready=0 (saturating)
//   dbg_state    out  FSM state: 0 IDLE, 1 FETCH, 2 WAIT, 3 VALID, 4 HALTED
//
// Handshake: a transfer happens at any rising edge where ir_valid and
// ir_ready are both 1. While ir_valid is 1, ir does not change. ir_valid
// only drops after a transfer, a redirect or a reset.
//
// Build option: define INSTR_FETCH_PERF_CNT_EN to build the two
// performance counters. Without it, instr_count and stall_count are
// tied to zero.
module instr_fetch #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [4:0]        HALT_OP  = 5'b11111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [31:0]       instr_count,
  output logic [31:0]       stall_count,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_VALID  = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0] state;

  assign imem_en   = (state == S_FETCH);
  assign imem_addr = pc;
  assign ir_valid  = (state == S_VALID);
  assign halted    = (state == S_HALTED);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      case (state)
        // Parked states: a jump only retargets the PC.
        // If start and jump_en arrive together, fetch begins at the new target.
        S_IDLE, S_HALTED: begin
          if (jump_en) pc <= jump_addr;
          if (start) state <= S_FETCH;
        end
        // A redirect here re-issues the read at the new PC. The stale
        // data returning next cycle is never sampled.
        S_FETCH: begin
          if (jump_en) pc <= jump_addr;
          else         state <= S_WAIT;
        end
        // A redirect beats both the returning word and a HALT decode.
        // The PC is not incremented in that case.
        S_WAIT: begin
          if (jump_en) begin
            pc    <= jump_addr;
            state <= S_FETCH;
          end else begin
            pc <= pc + PC_STEP;
            if (imem_rdata[31:27] == HALT_OP) begin
              state <= S_HALTED;
            end else begin
              ir    <= imem_rdata;
              state <= S_VALID;
            end
          end
        end
        // A redirect drops an unconsumed ir. A redirect that coincides with
        // ir_ready still counts as a completed transfer.
        S_VALID: begin
          if (jump_en) begin
            pc    <= jump_addr;
            state <= S_FETCH;
          end else if (ir_ready) begin
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [31:0] instr_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (state == S_VALID) begin
      if (ir_ready) begin
        if (instr_cnt_q != 32'hFFFF_FFFF) instr_cnt_q <= instr_cnt_q + 32'd1;
      end else begin
        if (stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign instr_count = instr_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign instr_count = 32'h0;
  assign stall_count = 32'h0;
`endif

endmodule
